time_keeper: RTL and testbench

Time-of-day counter for the alarm clock; the consumer of the one-second square wave produced by the clock divider. Detects each rising edge of `clk_sec`, advances an hours/minutes/seconds count in binary, supports synchronous time and alarm loading, and drives an alarm-ring output with acknowledge and automatic timeout. Sits between the divider and the display/buzzer logic in the `clk` domain.

---
 rtl/time_keeper.sv | 157 +++++++++++++++
 tb/tb_time_keeper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day counter with alarm ring (optional alarm: TIME_KEEPER_ALARM_EN)
module time_keeper #(
  parameter int HOURS_MAX    = 24,
  parameter int RING_SECONDS = 60
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clk_sec,
  input  logic        time_we,
  input  logic [16:0] time_in,
  input  logic        alarm_we,
  input  logic [10:0] alarm_in,
  input  logic        alarm_arm,
  input  logic        alarm_ack,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        sec_tick,
  output logic        alarm_ring
);

  logic       r_sec_prev;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  logic       r_sec_tick;

  logic       w_tick;
  logic       w_time_ld;
  logic       w_count;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hr_wrap;
  logic [5:0] w_nxt_sec;
  logic [5:0] w_nxt_min;
  logic [4:0] w_nxt_hr;

  // Rising edge of the one-second wave; a level held high or low gives no further ticks.
  assign w_tick = clk_sec & ~r_sec_prev;

  // A time load is accepted only when every field is in range; a valid load displaces the tick.
  assign w_time_ld = time_we && (time_in[5:0] <= 6'd59) && (time_in[11:6] <= 6'd59)
                     && (time_in[16:12] < 5'(HOURS_MAX));
  assign w_count   = w_tick & ~w_time_ld;

  assign w_sec_wrap = (r_seconds == 6'd59);
  assign w_min_wrap = (r_minutes == 6'd59);
  assign w_hr_wrap  = (r_hours == 5'(HOURS_MAX - 1));
  assign w_nxt_sec  = w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
  assign w_nxt_min  = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_minutes + 6'd1) : r_minutes;
  assign w_nxt_hr   = (w_sec_wrap && w_min_wrap) ? (w_hr_wrap ? 5'd0 : r_hours + 5'd1) : r_hours;

  // Edge-detect history, time registers and the registered per-second pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sec_prev <= 1'b0;
      r_hours    <= 5'd0;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_prev <= clk_sec;
      r_sec_tick <= w_count;
      if (w_time_ld) begin
        r_hours   <= time_in[16:12];
        r_minutes <= time_in[11:6];
        r_seconds <= time_in[5:0];
      end else if (w_tick) begin
        r_hours   <= w_nxt_hr;
        r_minutes <= w_nxt_min;
        r_seconds <= w_nxt_sec;
      end
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign sec_tick = r_sec_tick;

`ifdef TIME_KEEPER_ALARM_EN
  localparam int RW = $clog2(RING_SECONDS + 1);

  typedef enum logic {ST_IDLE, ST_RING} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_alarm_hh;
  logic [5:0]  r_alarm_mm;
  logic [RW-1:0] r_ring_cnt;
  logic [RW-1:0] w_ring_cnt_nxt;
  logic        w_alarm_ld;
  logic        w_match;

  assign w_alarm_ld = alarm_we && (alarm_in[5:0] <= 6'd59) && (alarm_in[10:6] < 5'(HOURS_MAX));

  // Only a counted tick that lands on hh:mm:00 can trigger; direct time loads never do.
  assign w_match = w_count && alarm_arm && (w_nxt_hr == r_alarm_hh)
                   && (w_nxt_min == r_alarm_mm) && (w_nxt_sec == 6'd0);

  // Alarm time register, independent of ticks and ringing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alarm_hh <= 5'd0;
      r_alarm_mm <= 6'd0;
    end else if (w_alarm_ld) begin
      r_alarm_hh <= alarm_in[10:6];
      r_alarm_mm <= alarm_in[5:0];
    end
  end

  // Alarm state and ring-duration counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
    end
  end

  // Next state: trigger beats a coincident ack; ack/disarm/timeout end the ring.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_nxt    = ST_RING;
          w_ring_cnt_nxt = '0;
        end
      end
      ST_RING: begin
        if (alarm_ack || !alarm_arm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_count) begin
          w_ring_cnt_nxt = r_ring_cnt + 1'b1;
          if (r_ring_cnt == RW'(RING_SECONDS - 1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign alarm_ring = (r_state == ST_RING);
`else
  logic w_unused_alarm;

  // Alarm inputs have no effect in the timekeeping-only build.
  assign w_unused_alarm = ^{alarm_we, alarm_in, alarm_arm, alarm_ack};
  assign alarm_ring     = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

`ifdef TIME_KEEPER_ALARM_EN
  localparam logic RING_EN = 1'b1;
`else
  localparam logic RING_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clk_sec = 1'b0;
  logic        time_we = 1'b0;
  logic [16:0] time_in = '0;
  logic        alarm_we = 1'b0;
  logic [10:0] alarm_in = '0;
  logic        alarm_arm = 1'b0;
  logic        alarm_ack = 1'b0;

  logic [4:0]  hours, hours12;
  logic [5:0]  minutes, minutes12;
  logic [5:0]  seconds, seconds12;
  logic        sec_tick, sec_tick12;
  logic        alarm_ring, alarm_ring12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_keeper #(.HOURS_MAX(24), .RING_SECONDS(60)) dut (
    .clk(clk), .rstn(rstn), .clk_sec(clk_sec), .time_we(time_we), .time_in(time_in),
    .alarm_we(alarm_we), .alarm_in(alarm_in), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .hours(hours), .minutes(minutes), .seconds(seconds), .sec_tick(sec_tick),
    .alarm_ring(alarm_ring)
  );

  time_keeper #(.HOURS_MAX(12), .RING_SECONDS(60)) dut12 (
    .clk(clk), .rstn(rstn), .clk_sec(clk_sec), .time_we(time_we), .time_in(time_in),
    .alarm_we(alarm_we), .alarm_in(alarm_in), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .hours(hours12), .minutes(minutes12), .seconds(seconds12), .sec_tick(sec_tick12),
    .alarm_ring(alarm_ring12)
  );

  task automatic tick();
    @(negedge clk); clk_sec = 1'b1;
    @(negedge clk); clk_sec = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk); time_we = 1'b1; time_in = {h, m, s};
    @(negedge clk); time_we = 1'b0;
  endtask

  task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
    @(negedge clk); alarm_we = 1'b1; alarm_in = {h, m};
    @(negedge clk); alarm_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({hours, minutes, seconds} !== 17'd0) begin
      errors++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
    end
    checks++;
    if ({sec_tick, alarm_ring} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got tick=%b ring=%b want 0 0", sec_tick, alarm_ring);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_rollover();
    load_time(5'd23, 6'd59, 6'd58);
    checks++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58}) begin
      errors++; $display("FAIL load_2359 got %0d:%0d:%0d want 23:59:58", hours, minutes, seconds);
    end
    tick();
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd23, 6'd59, 6'd59, 1'b1}) begin
      errors++; $display("FAIL tick_2359 got %0d:%0d:%0d tick=%b want 23:59:59 tick=1",
                         hours, minutes, seconds, sec_tick);
    end
    @(negedge clk);
    checks++;
    if (sec_tick !== 1'b0) begin
      errors++; $display("FAIL tick_width got %b want 0", sec_tick);
    end
    tick();
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      errors++; $display("FAIL midnight got %0d:%0d:%0d tick=%b want 0:0:0 tick=1",
                         hours, minutes, seconds, sec_tick);
    end
    load_time(5'd11, 6'd59, 6'd59);
    tick();
    checks++;
    if ({hours12, minutes12, seconds12} !== 17'd0) begin
      errors++; $display("FAIL wrap12 got %0d:%0d:%0d want 0:0:0", hours12, minutes12, seconds12);
    end
    checks++;
    if ({hours, minutes, seconds} !== {5'd12, 6'd0, 6'd0}) begin
      errors++; $display("FAIL noon24 got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
    end
  endtask

  task automatic test_invalid_load();
    load_time(5'd5, 6'd60, 6'd0);
    checks++;
    if ({hours, minutes, seconds} !== {5'd12, 6'd0, 6'd0}) begin
      errors++; $display("FAIL bad_min got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
    end
    load_time(5'd24, 6'd0, 6'd0);
    checks++;
    if ({hours, minutes, seconds} !== {5'd12, 6'd0, 6'd0}) begin
      errors++; $display("FAIL bad_hr got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
    end
    load_time(5'd1, 6'd2, 6'd60);
    checks++;
    if ({hours, minutes, seconds} !== {5'd12, 6'd0, 6'd0}) begin
      errors++; $display("FAIL bad_sec got %0d:%0d:%0d want 12:0:0", hours, minutes, seconds);
    end
    load_time(5'd12, 6'd5, 6'd0);
    checks++;
    if ({hours, minutes, seconds, hours12, minutes12, seconds12} !==
        {5'd12, 6'd5, 6'd0, 5'd0, 6'd0, 6'd0}) begin
      errors++; $display("FAIL hr12_limit got %0d:%0d:%0d / %0d:%0d:%0d want 12:5:0 / 0:0:0",
                         hours, minutes, seconds, hours12, minutes12, seconds12);
    end
  endtask

  task automatic test_load_vs_tick();
    @(negedge clk); clk_sec = 1'b1; time_we = 1'b1; time_in = {5'd10, 6'd0, 6'd0};
    @(negedge clk); clk_sec = 1'b0; time_we = 1'b0;
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd10, 6'd0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL load_wins got %0d:%0d:%0d tick=%b want 10:0:0 tick=0",
                         hours, minutes, seconds, sec_tick);
    end
    tick();
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd10, 6'd0, 6'd1, 1'b1}) begin
      errors++; $display("FAIL after_load got %0d:%0d:%0d tick=%b want 10:0:1 tick=1",
                         hours, minutes, seconds, sec_tick);
    end
    @(negedge clk); clk_sec = 1'b1; time_we = 1'b1; time_in = {5'd5, 6'd60, 6'd0};
    @(negedge clk); clk_sec = 1'b0; time_we = 1'b0;
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd10, 6'd0, 6'd2, 1'b1}) begin
      errors++; $display("FAIL bad_load_tick got %0d:%0d:%0d tick=%b want 10:0:2 tick=1",
                         hours, minutes, seconds, sec_tick);
    end
  endtask

  task automatic test_stuck_high();
    @(negedge clk); clk_sec = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({hours, minutes, seconds, sec_tick} !== {5'd10, 6'd0, 6'd3, 1'b0}) begin
      errors++; $display("FAIL stuck_high got %0d:%0d:%0d tick=%b want 10:0:3 tick=0",
                         hours, minutes, seconds, sec_tick);
    end
    clk_sec = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (seconds !== 6'd3) begin
      errors++; $display("FAIL stuck_low got %0d want 3", seconds);
    end
  endtask

  task automatic test_alarm_timeout();
    alarm_arm = 1'b1;
    load_alarm(5'd7, 6'd30);
    load_alarm(5'd7, 6'd60);
    load_time(5'd7, 6'd29, 6'd59);
    tick();
    checks++;
    if ({hours, minutes, seconds, alarm_ring} !== {5'd7, 6'd30, 6'd0, RING_EN}) begin
      errors++; $display("FAIL alarm_trig got %0d:%0d:%0d ring=%b want 7:30:0 ring=%b",
                         hours, minutes, seconds, alarm_ring, RING_EN);
    end
    ticks(59);
    checks++;
    if ({seconds, alarm_ring} !== {6'd59, RING_EN}) begin
      errors++; $display("FAIL ring_59 got sec=%0d ring=%b want 59 ring=%b", seconds, alarm_ring, RING_EN);
    end
    tick();
    checks++;
    if ({hours, minutes, seconds, alarm_ring} !== {5'd7, 6'd31, 6'd0, 1'b0}) begin
      errors++; $display("FAIL ring_timeout got %0d:%0d:%0d ring=%b want 7:31:0 ring=0",
                         hours, minutes, seconds, alarm_ring);
    end
  endtask

  task automatic test_ack_disarm();
    load_time(5'd7, 6'd29, 6'd59);
    @(negedge clk); clk_sec = 1'b1; alarm_ack = 1'b1;
    @(negedge clk); clk_sec = 1'b0; alarm_ack = 1'b0;
    checks++;
    if (alarm_ring !== RING_EN) begin
      errors++; $display("FAIL trig_beats_ack got %b want %b", alarm_ring, RING_EN);
    end
    load_time(5'd8, 6'd0, 6'd0);
    checks++;
    if ({hours, alarm_ring} !== {5'd8, RING_EN}) begin
      errors++; $display("FAIL load_in_ring got hr=%0d ring=%b want 8 ring=%b", hours, alarm_ring, RING_EN);
    end
    @(negedge clk); alarm_ack = 1'b1;
    @(negedge clk); alarm_ack = 1'b0;
    checks++;
    if (alarm_ring !== 1'b0) begin
      errors++; $display("FAIL ack got %b want 0", alarm_ring);
    end
    load_time(5'd7, 6'd29, 6'd59);
    tick();
    @(negedge clk); alarm_arm = 1'b0;
    @(negedge clk); alarm_arm = 1'b1;
    checks++;
    if (alarm_ring !== 1'b0) begin
      errors++; $display("FAIL disarm got %b want 0", alarm_ring);
    end
    load_time(5'd7, 6'd30, 6'd0);
    tick();
    checks++;
    if ({hours, minutes, seconds, alarm_ring} !== {5'd7, 6'd30, 6'd1, 1'b0}) begin
      errors++; $display("FAIL direct_load got %0d:%0d:%0d ring=%b want 7:30:1 ring=0",
                         hours, minutes, seconds, alarm_ring);
    end
  endtask

  task automatic test_reset_midring();
    load_time(5'd7, 6'd29, 6'd59);
    tick();
    @(negedge clk); rstn = 1'b0;
    #1;
    checks++;
    if ({alarm_ring, hours, minutes, seconds} !== 18'd0) begin
      errors++; $display("FAIL async_reset got ring=%b %0d:%0d:%0d want 0 0:0:0",
                         alarm_ring, hours, minutes, seconds);
    end
    @(negedge clk); clk_sec = 1'b1; rstn = 1'b1;
    @(negedge clk); clk_sec = 1'b0;
    checks++;
    if ({seconds, sec_tick} !== {6'd1, 1'b1}) begin
      errors++; $display("FAIL high_at_release got sec=%0d tick=%b want 1 tick=1", seconds, sec_tick);
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_invalid_load();
    test_load_vs_tick();
    test_stuck_high();
    test_alarm_timeout();
    test_ack_disarm();
    test_reset_midring();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
